// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, MEM-stage and RAM-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/RAM environment.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  ram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_be,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output ram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_be,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency RAM port between the fetch stage and the MEM stage,
// one transaction outstanding, MEM-priority with alternation under contention.
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input logic               Clock,
    input logic               Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    owner_t             owner_q, owner_d;
    owner_t             last_q, last_d;
    logic               store_q, store_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;

    logic               if_rvalid_c, mem_rvalid_c;
    logic               if_elig_c, mem_elig_c;
    logic               grant_ok_c;
    logic               if_gnt_c, mem_gnt_c;
    logic               ram_en_c, ram_we_c;
    logic [DATA_W-1:0]  ram_addr_c, ram_wdata_c;
    logic [3:0]         ram_be_c;

    // State, counter, ownership and captured read data
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            store_q     <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            store_q     <= store_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state, grant and RAM strobe decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        store_d     = store_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_gnt_c    = 1'b0;
        mem_gnt_c   = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        ram_be_c    = '0;

        if_rvalid_c  = (state_q == RESP) && (owner_q == OWN_IF);
        mem_rvalid_c = (state_q == RESP) && (owner_q == OWN_MEM);

        // A requester whose response is on the bus this cycle is not yet asking again
        if_elig_c  = bus.if_req  && !if_rvalid_c;
        mem_elig_c = bus.mem_req && !mem_rvalid_c;
        grant_ok_c = (state_q != WAIT) && !Reset;

        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = bus.ram_rdata;
                    end else begin
                        mem_rdata_d = store_q ? '0 : bus.ram_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (grant_ok_c) begin
            if (mem_elig_c && (!if_elig_c || (last_q == OWN_IF))) begin
                mem_gnt_c   = 1'b1;
                ram_en_c    = 1'b1;
                ram_we_c    = bus.mem_we;
                ram_addr_c  = bus.mem_addr;
                ram_wdata_c = bus.mem_wdata;
                ram_be_c    = bus.mem_be;
                owner_d     = OWN_MEM;
                last_d      = OWN_MEM;
                store_d     = bus.mem_we;
                cnt_d       = CNT_LOAD;
                state_d     = WAIT;
            end else if (if_elig_c) begin
                if_gnt_c    = 1'b1;
                ram_en_c    = 1'b1;
                ram_addr_c  = bus.if_addr;
                ram_be_c    = 4'hF;
                owner_d     = OWN_IF;
                last_d      = OWN_IF;
                store_d     = 1'b0;
                cnt_d       = CNT_LOAD;
                state_d     = WAIT;
            end
        end
    end

    assign bus.if_gnt     = if_gnt_c;
    assign bus.if_rvalid  = if_rvalid_c;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_gnt    = mem_gnt_c;
    assign bus.mem_rvalid = mem_rvalid_c;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.ram_en     = ram_en_c;
    assign bus.ram_we     = ram_we_c;
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_wdata  = ram_wdata_c;
    assign bus.ram_be     = ram_be_c;
    assign bus.stall_if   = bus.if_req  & ~if_rvalid_c;
    assign bus.stall_mem  = bus.mem_req & ~mem_rvalid_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_STATES=2, one at WAIT_STATES=1.
module tb_mem_port_arbiter;

    logic Clock;
    logic Reset;

    mem_port_arbiter_if u_if  ();
    mem_port_arbiter_if u_if1 ();

    mem_port_arbiter #(.WAIT_STATES(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (u_if)
    );

    mem_port_arbiter #(.WAIT_STATES(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (u_if1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_if_d;
    logic [31:0] exp_mem_d;
    logic        is_mem;

    initial begin
        Reset = 1'b1;
        u_if.if_req = 0;  u_if.if_addr = 0;
        u_if.mem_req = 0; u_if.mem_we = 0; u_if.mem_addr = 0; u_if.mem_wdata = 0; u_if.mem_be = 0;
        u_if.ram_rdata = 0;
        u_if1.if_req = 0;  u_if1.if_addr = 0;
        u_if1.mem_req = 0; u_if1.mem_we = 0; u_if1.mem_addr = 0; u_if1.mem_wdata = 0; u_if1.mem_be = 0;
        u_if1.ram_rdata = 0;
        #2;
        chk1 ("rst_if_gnt",    u_if.if_gnt,    1'b0);
        chk1 ("rst_mem_gnt",   u_if.mem_gnt,   1'b0);
        chk1 ("rst_if_rvalid", u_if.if_rvalid, 1'b0);
        chk1 ("rst_ram_en",    u_if.ram_en,    1'b0);
        chk32("rst_if_rdata",  u_if.if_rdata,  32'h0);
        chk32("rst_mem_rdata", u_if.mem_rdata, 32'h0);
        tick(); tick();
        Reset = 1'b0;

        // Single fetch, WAIT_STATES=2
        u_if.if_req = 1; u_if.if_addr = 32'h100; settle();
        chk1 ("f_gnt",      u_if.if_gnt,    1'b1);
        chk1 ("f_ram_en",   u_if.ram_en,    1'b1);
        chk32("f_ram_addr", u_if.ram_addr,  32'h100);
        chk1 ("f_ram_we",   u_if.ram_we,    1'b0);
        chk32("f_ram_be",   32'(u_if.ram_be), 32'hF);
        chk32("f_ram_wd",   u_if.ram_wdata, 32'h0);
        chk1 ("f_mem_gnt",  u_if.mem_gnt,   1'b0);
        chk1 ("f_stall_t0", u_if.stall_if,  1'b1);
        tick(); settle();
        chk1 ("f_gnt_t1",   u_if.if_gnt,    1'b0);
        chk1 ("f_en_t1",    u_if.ram_en,    1'b0);
        chk32("f_addr_t1",  u_if.ram_addr,  32'h0);
        chk1 ("f_stall_t1", u_if.stall_if,  1'b1);
        chk1 ("f_rv_t1",    u_if.if_rvalid, 1'b0);
        tick(); u_if.ram_rdata = 32'hDEADBEEF; settle();
        chk1 ("f_stall_t2", u_if.stall_if,  1'b1);
        chk1 ("f_rv_t2",    u_if.if_rvalid, 1'b0);
        tick(); u_if.ram_rdata = 32'h0; settle();
        chk1 ("f_rv_t3",    u_if.if_rvalid, 1'b1);
        chk32("f_rdata_t3", u_if.if_rdata,  32'hDEADBEEF);
        chk1 ("f_stall_t3", u_if.stall_if,  1'b0);
        chk1 ("f_regnt_t3", u_if.if_gnt,    1'b0);
        u_if.if_req = 0; settle();
        tick(); settle();
        chk1 ("f_rv_t4",    u_if.if_rvalid, 1'b0);
        chk32("f_hold_t4",  u_if.if_rdata,  32'hDEADBEEF);

        // Fresh reset, then both requesters held for six alternating transactions
        Reset = 1'b1; tick(); Reset = 1'b0; settle();
        chk32("rst2_if_rdata", u_if.if_rdata, 32'h0);
        exp_if_d = 0; exp_mem_d = 0;
        u_if.mem_req = 1; u_if.mem_we = 0; u_if.mem_addr = 32'h200; u_if.mem_be = 4'hF;
        u_if.if_req = 1;  u_if.if_addr = 32'h300;
        settle();
        for (int i = 0; i < 6; i++) begin
            is_mem = (i % 2 == 0);
            chk1 ("alt_mem_gnt", u_if.mem_gnt, is_mem);
            chk1 ("alt_if_gnt",  u_if.if_gnt,  !is_mem);
            chk32("alt_addr",    u_if.ram_addr, is_mem ? 32'h200 : 32'h300);
            tick(); settle();
            chk1 ("alt_w1_en",   u_if.ram_en,  1'b0);
            tick(); u_if.ram_rdata = 32'hA000_0000 + 32'(i); settle();
            chk1 ("alt_w2_gnt",  u_if.if_gnt | u_if.mem_gnt, 1'b0);
            tick(); u_if.ram_rdata = 32'h0;
            if (is_mem) exp_mem_d = 32'hA000_0000 + 32'(i);
            else        exp_if_d  = 32'hA000_0000 + 32'(i);
            if (i == 5) begin u_if.mem_req = 0; u_if.if_req = 0; end
            settle();
            chk1 ("alt_mem_rv",  u_if.mem_rvalid, is_mem);
            chk1 ("alt_if_rv",   u_if.if_rvalid,  !is_mem);
            chk32("alt_if_rd",   u_if.if_rdata,   exp_if_d);
            chk32("alt_mem_rd",  u_if.mem_rdata,  exp_mem_d);
        end
        chk1 ("alt_end_gnt", u_if.if_gnt | u_if.mem_gnt, 1'b0);
        tick();

        // Store; request dropped after grant still answered, fetch raised/dropped in WAIT ignored
        u_if.mem_req = 1; u_if.mem_we = 1; u_if.mem_addr = 32'h40;
        u_if.mem_wdata = 32'h1234; u_if.mem_be = 4'b0011; settle();
        chk1 ("st_gnt",   u_if.mem_gnt,   1'b1);
        chk1 ("st_we",    u_if.ram_we,    1'b1);
        chk32("st_be",    32'(u_if.ram_be), 32'h3);
        chk32("st_wd",    u_if.ram_wdata, 32'h1234);
        chk32("st_addr",  u_if.ram_addr,  32'h40);
        tick();
        u_if.mem_req = 0; u_if.mem_we = 0; u_if.if_req = 1; u_if.if_addr = 32'h700; settle();
        chk1 ("st_w_ifgnt", u_if.if_gnt,   1'b0);
        chk1 ("st_w_we",    u_if.ram_we,   1'b0);
        chk32("st_w_be",    32'(u_if.ram_be), 32'h0);
        chk32("st_w_wd",    u_if.ram_wdata, 32'h0);
        chk1 ("st_w_stall", u_if.stall_mem, 1'b0);
        tick(); u_if.if_req = 0; u_if.ram_rdata = 32'hFFFF_FFFF; settle();
        chk1 ("st_w2_rv",   u_if.mem_rvalid, 1'b0);
        tick(); u_if.ram_rdata = 32'h0; settle();
        chk1 ("st_rv",      u_if.mem_rvalid, 1'b1);
        chk32("st_rdata",   u_if.mem_rdata,  32'h0);
        chk1 ("st_ifgnt",   u_if.if_gnt,     1'b0);
        chk32("st_if_hold", u_if.if_rdata,   exp_if_d);
        tick();

        // Reset pulsed during WAIT of a fetch
        u_if.if_req = 1; u_if.if_addr = 32'h500; settle();
        chk1 ("rw_gnt", u_if.if_gnt, 1'b1);
        tick(); Reset = 1'b1; settle();
        chk1 ("rw_r_gnt",  u_if.if_gnt,    1'b0);
        chk1 ("rw_r_en",   u_if.ram_en,    1'b0);
        chk32("rw_r_addr", u_if.ram_addr,  32'h0);
        chk1 ("rw_r_rv",   u_if.if_rvalid, 1'b0);
        chk32("rw_r_rd",   u_if.if_rdata,  32'h0);
        chk32("rw_r_mrd",  u_if.mem_rdata, 32'h0);
        tick(); u_if.ram_rdata = 32'hCAFE_0000; settle();
        chk1 ("rw_r2_gnt", u_if.if_gnt,    1'b0);
        chk1 ("rw_r2_rv",  u_if.if_rvalid, 1'b0);
        Reset = 1'b0; u_if.ram_rdata = 32'h0; settle();
        chk1 ("rw_rel_gnt",  u_if.if_gnt,   1'b1);
        chk32("rw_rel_addr", u_if.ram_addr, 32'h500);
        tick(); settle();
        chk1 ("rw_g1_rv", u_if.if_rvalid, 1'b0);
        tick(); u_if.ram_rdata = 32'h5555_AAAA; settle();
        chk1 ("rw_g2_rv", u_if.if_rvalid, 1'b0);
        tick(); u_if.ram_rdata = 32'h0; settle();
        chk1 ("rw_g3_rv", u_if.if_rvalid, 1'b1);
        chk32("rw_g3_rd", u_if.if_rdata,  32'h5555_AAAA);
        u_if.if_req = 0;
        tick();

        // WAIT_STATES=1, single fetch requester re-requesting
        u_if1.if_req = 1; u_if1.if_addr = 32'h600; settle();
        chk1 ("w1_gnt0", u_if1.if_gnt, 1'b1);
        tick(); u_if1.ram_rdata = 32'h77; settle();
        chk1 ("w1_rv0_early", u_if1.if_rvalid, 1'b0);
        tick(); u_if1.ram_rdata = 32'h0; settle();
        chk1 ("w1_rv0",   u_if1.if_rvalid, 1'b1);
        chk32("w1_rd0",   u_if1.if_rdata,  32'h77);
        chk1 ("w1_nogn",  u_if1.if_gnt,    1'b0);
        tick(); settle();
        chk1 ("w1_gnt1", u_if1.if_gnt, 1'b1);
        tick(); u_if1.ram_rdata = 32'h88; settle();
        chk1 ("w1_rv1_early", u_if1.if_rvalid, 1'b0);
        tick(); u_if1.ram_rdata = 32'h0; settle();
        chk1 ("w1_rv1", u_if1.if_rvalid, 1'b1);
        chk32("w1_rd1", u_if1.if_rdata,  32'h88);
        u_if1.if_req = 0;
        tick();

        // WAIT_STATES=1, both requesters: a grant every 2 cycles
        u_if1.if_req = 1;  u_if1.if_addr = 32'h610;
        u_if1.mem_req = 1; u_if1.mem_addr = 32'h620; u_if1.mem_be = 4'hF; settle();
        chk1 ("w1b_mgnt", u_if1.mem_gnt, 1'b1);
        tick(); u_if1.ram_rdata = 32'h1; settle();
        chk1 ("w1b_wgnt", u_if1.if_gnt | u_if1.mem_gnt, 1'b0);
        tick(); u_if1.ram_rdata = 32'h0; settle();
        chk1 ("w1b_mrv",  u_if1.mem_rvalid, 1'b1);
        chk32("w1b_mrd",  u_if1.mem_rdata,  32'h1);
        chk1 ("w1b_ignt", u_if1.if_gnt,     1'b1);
        tick(); u_if1.ram_rdata = 32'h2; settle();
        tick(); u_if1.ram_rdata = 32'h0; settle();
        chk1 ("w1b_irv",  u_if1.if_rvalid, 1'b1);
        chk32("w1b_ird",  u_if1.if_rdata,  32'h2);
        chk1 ("w1b_mgnt2", u_if1.mem_gnt,  1'b1);
        u_if1.if_req = 0; u_if1.mem_req = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
